// File: rtl/shifter_pkg.sv
// Shared types and helpers for the serial right shifter.
// Imported by the top-level shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int AMT_W_DEF = 4;

  function automatic int clamp_amt(
    input int amt,
    input int lim
  );
    return (amt > lim) ? lim : amt;
  endfunction

endpackage

// File: rtl/shift_down_counter.sv
// Loadable down-counter with a terminal-count flag.
// Used to pace iterative units.
module shift_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/serial_right_shifter.sv
// Multi-cycle logical right shifter, one bit per clock.
// Reports discarded 1-bits and whether the result fits 4 bits.
module serial_right_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lost,
  output logic             out_fits
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             lost_q;
  logic             lost_d;
  logic             fits_q;
  logic             fits_d;
  logic             in_ready_q;
  logic             in_ready_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_last;
  logic [CNT_W-1:0] n;

  // Amounts past WIDTH just flush the register, so cap the count there.
  assign n = CNT_W'(clamp_amt(int'(in_amt), WIDTH));

  shift_down_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (n),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    lost_d      = lost_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d     = in_data;
          lost_d     = 1'b0;
          in_ready_d = 1'b0;
          cnt_load   = 1'b1;
          if (n == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        lost_d  = lost_q | data_q[0];
        data_d  = {1'b0, data_q[WIDTH-1:1]};
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
    fits_d = (data_d[WIDTH-1:4] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      lost_q      <= 1'b0;
      fits_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      lost_q      <= lost_d;
      fits_q      <= fits_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_lost  = lost_q;
  assign out_fits  = fits_q;

endmodule

// File: tb/tb_serial_right_shifter.sv
// Self-checking bench for serial_right_shifter.
// Table vectors, corner sequences and a random reference-model sweep.
module tb_serial_right_shifter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_lost;
  logic       out_fits;

  int total;
  int bad;

  serial_right_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lost  (out_lost),
    .out_fits  (out_fits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] amt;
    logic [7:0] exp_data;
    logic       exp_lost;
    logic       exp_fits;
    int         exp_lat;
    int         hold;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_lost"}, int'(out_lost), 0);
    chk({tag, "_out_fits"}, int'(out_fits), 1);
  endtask

  // Issue one request from a negedge; returns at the negedge after handoff.
  task automatic run_req(
    input string      name,
    input logic [7:0] d,
    input logic [3:0] a,
    input logic [7:0] ed,
    input logic       el,
    input logic       ef,
    input int         elat,
    input int         hold,
    input bit         rnd_ready
  );
    int lat;
    chk({name, "_ready_pre"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_amt   = ~a;
    lat = 1;
    while (!out_valid && lat < 20) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) begin
      bad++;
      total++;
      $display("FAIL %s_timeout got=no_valid want=valid", name);
      return;
    end
    chk({name, "_lat"}, lat, elat);
    chk({name, "_data"}, int'(out_data), int'(ed));
    chk({name, "_lost"}, int'(out_lost), int'(el));
    chk({name, "_fits"}, int'(out_fits), int'(ef));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({name, "_bp_valid"}, int'(out_valid), 1);
      chk({name, "_bp_data"}, int'(out_data), int'(ed));
      chk({name, "_bp_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_post_valid"}, int'(out_valid), 0);
    chk({name, "_post_ready"}, int'(in_ready), 1);
  endtask

  vec_t vecs[8];

  initial begin
    int unsigned rd;
    int unsigned ra;
    int unsigned rexp;
    int unsigned ncap;
    bit          rlost;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b0;

    vecs[0] = '{8'hB0, 4'd4,  8'h0B, 1'b0, 1'b1, 5, 0};
    vecs[1] = '{8'hA5, 4'd0,  8'hA5, 1'b0, 1'b0, 1, 0};
    vecs[2] = '{8'h81, 4'd15, 8'h00, 1'b1, 1'b1, 9, 0};
    vecs[3] = '{8'h03, 4'd1,  8'h01, 1'b1, 1'b1, 2, 0};
    vecs[4] = '{8'hB0, 4'd4,  8'h0B, 1'b0, 1'b1, 5, 6};
    vecs[5] = '{8'hFF, 4'd8,  8'h00, 1'b1, 1'b1, 9, 0};
    vecs[6] = '{8'h40, 4'd2,  8'h10, 1'b0, 1'b0, 3, 0};
    vecs[7] = '{8'h80, 4'd7,  8'h01, 1'b0, 1'b1, 8, 2};

    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    // Ready asserted while idle must not create a result.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ready_ignored", int'(out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt,
              vecs[i].exp_data, vecs[i].exp_lost, vecs[i].exp_fits,
              vecs[i].exp_lat, vecs[i].hold, 1'b0);
    end

    // Reset in the middle of a shift discards the work.
    chk("midrst_ready_pre", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 8'hF0;
    in_amt   = 4'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst_rel");
    run_req("after_rst", 8'h10, 4'd4, 8'h01, 1'b0, 1'b1, 5, 0, 1'b0);

    // Round trips: A << B restored exactly.
    for (int i = 0; i < 12; i++) begin
      rd = $urandom_range(0, 15);
      ra = $urandom_range(0, 4);
      rexp = rd;
      run_req($sformatf("rt%0d", i), 8'((rd << ra) & 8'hFF), 4'(ra),
              8'(rexp), 1'b0, 1'b1, (ra == 0) ? 1 : int'(ra) + 1,
              0, 1'b1);
    end

    // Random sweep against an arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      rd    = $urandom_range(0, 255);
      ra    = $urandom_range(0, 15);
      rexp  = rd >> ra;
      rlost = ((rexp << ra) != rd);
      ncap  = (ra > 8) ? 8 : ra;
      run_req($sformatf("rnd%0d", i), 8'(rd), 4'(ra), 8'(rexp), rlost,
              rexp < 16, (ncap == 0) ? 1 : int'(ncap) + 1,
              int'($urandom_range(0, 2)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
